rgen_command_arbiter: RTL and testbench
=======================================

# rgen_command_arbiter

Shares one local register command bus between N_HOSTS host interfaces, e.g. an APB host and a debug host driving the same register block. It sits between the host-interface modules and the response mux / address decoders. Each requester's command is granted in round-robin order and driven downstream as a registered command. The downstream response is returned only to the granted requester.

## Interface
- N_HOSTS, 2: number of requesters, 2..8
- DATA_WIDTH, 32: local data width
- ADDRESS_WIDTH, 8: local byte-address width
- TIMEOUT_CYCLES, 255: cycles allowed for a downstream response (timeout build only)

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- i_command_valid  in  [N_HOSTS]  per-host command request, held until that host's response
- i_write, i_read  in  [N_HOSTS]  per-host access type
- i_address  in  [N_HOSTS][ADDRESS_WIDTH]  per-host address
- i_write_data, i_write_mask  in  [N_HOSTS][DATA_WIDTH]  per-host write payload
- o_response_ready  out  [N_HOSTS]  one-cycle response strobe to the granted host
- o_read_data  out  DATA_WIDTH  response data, shared, valid with strobe
- o_status  out  2  response status, shared, valid with strobe
- o_command_valid, o_write, o_read, o_address, o_write_data, o_write_mask  out  local bus command
- i_response_ready, i_read_data, i_status  in  local bus response

## Operation
- States: IDLE, BUSY, RESPONSE.
- **IDLE**
  - If any i_command_valid is set, pick a winner with the round-robin grant.
  - Register the winner's write, read, address, write_data and write_mask, and the grant index.
  - Go to BUSY.
- **BUSY**
  - o_command_valid = 1; the command fields are the registered copies and stay stable.
  - On i_response_ready: capture i_read_data and i_status, drop o_command_valid, go to RESPONSE.
- **RESPONSE**
  - o_response_ready[grant] = 1 for exactly one cycle, with the captured data and status.
  - Advance the pointer to grant+1 (mod N_HOSTS); go to IDLE.
- Round robin: the search starts at the pointer. The lowest index at or after the pointer wins, wrapping around.
- Reset pointer is 0; after reset, simultaneous requests grant host 0 first.
- A requester must drop i_command_valid in the cycle after its o_response_ready. A requester that drops valid while in BUSY is a protocol violation; the arbiter ignores it and completes the latched command.
- i_response_ready in IDLE or RESPONSE is ignored.
- Reset mid-transaction: abort immediately, go to IDLE, no response strobe. All outputs return to their reset values: every o_* is 0.

## Timing
- Request seen in IDLE at cycle t → o_command_valid high at t+1.
- i_response_ready at cycle k → o_response_ready[grant] high at k+1 → IDLE at k+2.
- Earliest next o_command_valid is k+3.
- Minimum service: 3 cycles per transaction plus downstream latency.
- o_read_data and o_status hold their last values outside RESPONSE; they are 0 after reset.
- No combinational path from any input to any output.

## Configuration
- Macro: RGEN_COMMAND_ARBITER_TIMEOUT_EN.
- **Defined**
  - An 8..16-bit cycle counter runs in BUSY, cleared on entry.
  - When the counter reaches TIMEOUT_CYCLES without i_response_ready, the arbiter drops o_command_valid and goes to RESPONSE.
  - The response is o_status = SLVERR and o_read_data = 0.
  - If a timeout and i_response_ready fall in the same cycle, the real response wins.
- **Undefined**
  - No counter; BUSY waits indefinitely. TIMEOUT_CYCLES is unused.

## Structure
- Shared package rgen_pkg holds:
  - typedef enum rgen_status: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - typedef enum for the arbiter state.
- Sub-module rgen_round_robin_grant: combinational. Takes a request vector and a pointer; returns a one-hot grant and its index. Reused by future arbiters.

## Test plan
- Single host 0 write, addr 0x04, data 0xDEADBEEF, mask 0xFFFFFFFF; downstream responds 2 cycles after o_command_valid → downstream fields match; o_response_ready[0] one cycle later with status OKAY; no strobe on host 1.
- Hosts 0 and 1 request in the same cycle after reset, both held → host 0 served first, then host 1. Repeat → host 0 again: pointer wraps.
- Host 1 read, downstream returns 0x12345678 with status SLVERR → host 1 sees 0x12345678 / 2'b10; the value holds afterwards.
- rst_n asserted while in BUSY → next cycle all outputs are 0 and the state is IDLE. After release, a pending host-0 request is granted with pointer 0.
- With RGEN_COMMAND_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, downstream never responds → o_command_valid drops after 16 cycles; the host gets SLVERR and data 0. A late i_response_ready is ignored.
- Continuous requests from all 4 hosts (N_HOSTS=4) → grants run 0,1,2,3,0. No command-field change during BUSY.

Source files
------------

// File: rtl/rgen_pkg.sv
// Shared types for the rgen register-command blocks: response status codes
// and the command arbiter state encoding.
package rgen_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } rgen_status;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'b00,
        ARB_BUSY     = 2'b01,
        ARB_RESPONSE = 2'b10
    } rgen_arb_state;

    localparam int unsigned RGEN_TIMEOUT_WIDTH = 16;

endpackage

// File: rtl/rgen_round_robin_grant.sv
// Combinational round-robin pick: the first requester at or after ptr wins,
// wrapping around. Returns a one-hot grant (all zero when idle) and its index.
module rgen_round_robin_grant #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW:0] cand;
    logic        found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
        if (found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/rgen_command_arbiter.sv
// Round-robin arbiter sharing one local register command bus between N_HOSTS hosts.
// Optional BUSY timeout is built when RGEN_COMMAND_ARBITER_TIMEOUT_EN is defined.
//
// state        | meaning
// ARB_IDLE     | waiting for a request; latches the winner's command
// ARB_BUSY     | command driven downstream, waiting for the response
// ARB_RESPONSE | one-cycle strobe to the granted host, pointer advances
module rgen_command_arbiter
    import rgen_pkg::*;
#(
    parameter int N_HOSTS        = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_HOSTS-1:0]                      i_command_valid,
    input  logic [N_HOSTS-1:0]                      i_write,
    input  logic [N_HOSTS-1:0]                      i_read,
    input  logic [N_HOSTS-1:0][ADDRESS_WIDTH-1:0]   i_address,
    input  logic [N_HOSTS-1:0][DATA_WIDTH-1:0]      i_write_data,
    input  logic [N_HOSTS-1:0][DATA_WIDTH-1:0]      i_write_mask,
    output logic [N_HOSTS-1:0]                      o_response_ready,
    output logic [DATA_WIDTH-1:0]                   o_read_data,
    output logic [1:0]                              o_status,
    output logic                                    o_command_valid,
    output logic                                    o_write,
    output logic                                    o_read,
    output logic [ADDRESS_WIDTH-1:0]                o_address,
    output logic [DATA_WIDTH-1:0]                   o_write_data,
    output logic [DATA_WIDTH-1:0]                   o_write_mask,
    input  logic                                    i_response_ready,
    input  logic [DATA_WIDTH-1:0]                   i_read_data,
    input  logic [1:0]                              i_status
);

    localparam int IW = $clog2(N_HOSTS);

    if (N_HOSTS < 2 || N_HOSTS > 8) begin : g_bad_hosts
        $error("rgen_command_arbiter: N_HOSTS must be 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("rgen_command_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    rgen_arb_state      state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      grant_idx;
    logic [N_HOSTS-1:0] win_grant;
    logic [IW-1:0]      win_idx;

`ifdef RGEN_COMMAND_ARBITER_TIMEOUT_EN
    logic [RGEN_TIMEOUT_WIDTH-1:0] tmo_cnt;
`endif

    rgen_round_robin_grant #(.N(N_HOSTS)) u_grant (
        .req   (i_command_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ARB_IDLE;
            ptr              <= '0;
            grant_idx        <= '0;
            o_command_valid  <= 1'b0;
            o_write          <= 1'b0;
            o_read           <= 1'b0;
            o_address        <= '0;
            o_write_data     <= '0;
            o_write_mask     <= '0;
            o_response_ready <= '0;
            o_read_data      <= '0;
            o_status         <= '0;
`ifdef RGEN_COMMAND_ARBITER_TIMEOUT_EN
            tmo_cnt          <= '0;
`endif
        end else begin
            o_response_ready <= '0;
            case (state)
                ARB_IDLE: begin
                    if (|win_grant) begin
                        grant_idx       <= win_idx;
                        o_write         <= i_write[win_idx];
                        o_read          <= i_read[win_idx];
                        o_address       <= i_address[win_idx];
                        o_write_data    <= i_write_data[win_idx];
                        o_write_mask    <= i_write_mask[win_idx];
                        o_command_valid <= 1'b1;
                        state           <= ARB_BUSY;
`ifdef RGEN_COMMAND_ARBITER_TIMEOUT_EN
                        // down-count: terminal count after TIMEOUT_CYCLES BUSY cycles
                        tmo_cnt         <= RGEN_TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
`endif
                    end
                end
                ARB_BUSY: begin
                    if (i_response_ready) begin
                        o_read_data                 <= i_read_data;
                        o_status                    <= i_status;
                        o_command_valid             <= 1'b0;
                        o_response_ready[grant_idx] <= 1'b1;
                        state                       <= ARB_RESPONSE;
                    end
`ifdef RGEN_COMMAND_ARBITER_TIMEOUT_EN
                    else if (tmo_cnt == '0) begin
                        o_read_data                 <= '0;
                        o_status                    <= SLVERR;
                        o_command_valid             <= 1'b0;
                        o_response_ready[grant_idx] <= 1'b1;
                        state                       <= ARB_RESPONSE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
`endif
                end
                ARB_RESPONSE: begin
                    ptr   <= (grant_idx == IW'(N_HOSTS - 1)) ? '0 : grant_idx + 1'b1;
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgen_command_arbiter.sv
// Directed bench for rgen_command_arbiter with four hosts; the timeout scenario
// follows RGEN_COMMAND_ARBITER_TIMEOUT_EN.
module tb_rgen_command_arbiter;
    import rgen_pkg::*;

    localparam int NH = 4;
    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NH-1:0]         cmd_valid = '0;
    logic [NH-1:0]         wr = '0;
    logic [NH-1:0]         rd = '0;
    logic [NH-1:0][AW-1:0] addr = '0;
    logic [NH-1:0][DW-1:0] wdata = '0;
    logic [NH-1:0][DW-1:0] wmask = '0;
    logic [NH-1:0]         rsp_strobe;
    logic [DW-1:0]         rsp_data;
    logic [1:0]            rsp_status;
    logic                  dn_valid, dn_write, dn_read;
    logic [AW-1:0]         dn_addr;
    logic [DW-1:0]         dn_wdata, dn_wmask;
    logic                  dn_ready = 1'b0;
    logic [DW-1:0]         dn_rdata = '0;
    logic [1:0]            dn_status = 2'b00;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rgen_command_arbiter #(
        .N_HOSTS(NH), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_command_valid  (cmd_valid),
        .i_write          (wr),
        .i_read           (rd),
        .i_address        (addr),
        .i_write_data     (wdata),
        .i_write_mask     (wmask),
        .o_response_ready (rsp_strobe),
        .o_read_data      (rsp_data),
        .o_status         (rsp_status),
        .o_command_valid  (dn_valid),
        .o_write          (dn_write),
        .o_read           (dn_read),
        .o_address        (dn_addr),
        .o_write_data     (dn_wdata),
        .o_write_mask     (dn_wmask),
        .i_response_ready (dn_ready),
        .i_read_data      (dn_rdata),
        .i_status         (dn_status)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_host(input int h, input logic w, input logic r, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] m);
        wr[h] = w; rd[h] = r; addr[h] = a; wdata[h] = d; wmask[h] = m;
        cmd_valid[h] = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"},  dn_valid,   0);
        check_eq({tag, "_write"},  dn_write,   0);
        check_eq({tag, "_read"},   dn_read,    0);
        check_eq({tag, "_addr"},   dn_addr,    0);
        check_eq({tag, "_wdata"},  dn_wdata,   0);
        check_eq({tag, "_wmask"},  dn_wmask,   0);
        check_eq({tag, "_strobe"}, rsp_strobe, 0);
        check_eq({tag, "_rdata"},  rsp_data,   0);
        check_eq({tag, "_status"}, rsp_status, 0);
    endtask

    // Called at an IDLE negedge with host h's request pending and expected to win.
    task automatic serve(input int h, input logic [DW-1:0] rdata, input logic [1:0] st, input int lat);
        logic          ew, er;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, em;
        logic [NH-1:0] es;
        ew = wr[h]; er = rd[h]; ea = addr[h]; ed = wdata[h]; em = wmask[h];
        es = '0; es[h] = 1'b1;
        step();
        check_eq("cmd_valid", dn_valid, 1);
        check_eq("cmd_write", dn_write, ew);
        check_eq("cmd_read",  dn_read,  er);
        check_eq("cmd_addr",  dn_addr,  ea);
        check_eq("cmd_wdata", dn_wdata, ed);
        check_eq("cmd_wmask", dn_wmask, em);
        addr[h]  = ~addr[h];
        wdata[h] = ~wdata[h];
        for (int i = 1; i < lat; i++) begin
            step();
            check_eq("busy_valid",  dn_valid,   1);
            check_eq("busy_addr",   dn_addr,    ea);
            check_eq("busy_wdata",  dn_wdata,   ed);
            check_eq("busy_strobe", rsp_strobe, 0);
        end
        dn_ready = 1'b1; dn_rdata = rdata; dn_status = st;
        step();
        dn_ready = 1'b0; dn_rdata = 32'hBAD0_BAD0; dn_status = 2'b11;
        cmd_valid[h] = 1'b0;
        check_eq("rsp_strobe", rsp_strobe, es);
        check_eq("rsp_data",   rsp_data,   rdata);
        check_eq("rsp_status", rsp_status, st);
        check_eq("rsp_cmd_drop", dn_valid, 0);
        step();
        check_eq("strobe_one_cycle", rsp_strobe, 0);
        check_eq("data_hold",   rsp_data,   rdata);
        check_eq("status_hold", rsp_status, st);
    endtask

    initial begin
        int n;
        // reset state
        step(); step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // single host-0 write, response 2 cycles after command
        set_host(0, 1'b1, 1'b0, 8'h04, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        serve(0, 32'h0, OKAY, 2);

        // simultaneous 0 and 1 after reset, then again to exercise wrap
        rst_n = 1'b0; step(); rst_n = 1'b1;
        set_host(0, 1'b1, 1'b0, 8'h10, 32'h0000_1111, 32'h0000_FFFF);
        set_host(1, 1'b0, 1'b1, 8'h14, 32'h0, 32'h0);
        serve(0, 32'h0000_0A0A, OKAY, 1);
        serve(1, 32'h0000_0B0B, EXOKAY, 2);
        set_host(0, 1'b1, 1'b0, 8'h18, 32'h2222_0000, 32'hFFFF_0000);
        set_host(1, 1'b1, 1'b0, 8'h1C, 32'h3333_3333, 32'h00FF_00FF);
        serve(0, 32'h0, OKAY, 1);
        serve(1, 32'h0, OKAY, 1);

        // host-1 read with SLVERR, values hold afterwards
        set_host(1, 1'b0, 1'b1, 8'h40, 32'h0, 32'h0);
        serve(1, 32'h1234_5678, SLVERR, 3);
        step(); step();
        check_eq("slverr_data_hold",   rsp_data,   32'h1234_5678);
        check_eq("slverr_status_hold", rsp_status, 2'b10);

        // pointer is 2: host 2 wins over host 0, then reset mid-BUSY
        set_host(0, 1'b1, 1'b0, 8'h20, 32'h0101_0101, 32'hFFFF_FFFF);
        set_host(2, 1'b0, 1'b1, 8'h28, 32'h0, 32'h0);
        step();
        check_eq("pre_reset_grant_addr", dn_addr, 8'h28);
        step();
        rst_n = 1'b0;
        #1;
        check_all_zero("midbusy_reset");
        step();
        check_eq("reset_held_valid", dn_valid, 0);
        rst_n = 1'b1;
        serve(0, 32'h5555_AAAA, OKAY, 1);
        serve(2, 32'hCAFE_F00D, DECERR, 2);

        // response strobe while idle is ignored
        dn_ready = 1'b1; dn_rdata = 32'h1111_1111; dn_status = EXOKAY;
        step();
        dn_ready = 1'b0;
        check_eq("idle_rsp_strobe", rsp_strobe, 0);
        check_eq("idle_rsp_data",   rsp_data,   32'hCAFE_F00D);
        step();
        check_eq("idle_rsp_strobe2", rsp_strobe, 0);
        check_eq("idle_rsp_status",  rsp_status, 2'b11);
        check_eq("idle_cmd_valid",   dn_valid,   0);

        // all four hosts continuously: 0,1,2,3,0
        rst_n = 1'b0; step(); rst_n = 1'b1;
        for (int h = 0; h < NH; h++)
            set_host(h, h[0], ~h[0], 8'(8'h80 + 4 * h), 32'(32'hA000_0000 + h), 32'(32'h0F00_0000 + h));
        for (int k = 0; k < 5; k++) begin
            serve(k % NH, 32'(32'h100 + k), OKAY, 3);
            if (k < 4) cmd_valid[k % NH] = 1'b1;
        end
        cmd_valid = '0;

        // no downstream response on host 3 (pointer is 1)
        set_host(3, 1'b0, 1'b1, 8'h3C, 32'h0, 32'h0);
        dn_rdata = 32'hA5A5_A5A5; dn_status = OKAY;
        step();
        check_eq("tmo_cmd_valid", dn_valid, 1);
        check_eq("tmo_cmd_read",  dn_read,  1);
`ifdef RGEN_COMMAND_ARBITER_TIMEOUT_EN
        n = 0;
        while (dn_valid === 1'b1 && n < 100) begin
            n++;
            step();
        end
        check_eq("tmo_busy_cycles", n, 16);
        check_eq("tmo_strobe", rsp_strobe, 4'b1000);
        check_eq("tmo_status", rsp_status, 2'b10);
        check_eq("tmo_data",   rsp_data,   0);
        cmd_valid[3] = 1'b0;
        dn_ready = 1'b1;
        step();
        dn_ready = 1'b0;
        check_eq("late_rsp_strobe", rsp_strobe, 0);
        check_eq("late_rsp_data",   rsp_data,   0);
        check_eq("late_rsp_status", rsp_status, 2'b10);
        step();
        check_eq("late_rsp_strobe2", rsp_strobe, 0);
`else
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dn_valid === 1'b1 && rsp_strobe === '0) n++;
        end
        check_eq("wait_cycles_held", n, 40);
        dn_ready = 1'b1;
        step();
        dn_ready = 1'b0;
        cmd_valid[3] = 1'b0;
        check_eq("wait_strobe", rsp_strobe, 4'b1000);
        check_eq("wait_data",   rsp_data,   32'hA5A5_A5A5);
        check_eq("wait_status", rsp_status, 2'b00);
        step();
        check_eq("wait_strobe_off", rsp_strobe, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
